// File: rtl/seq_detect_pkg.sv
// Shared types and default sizes for the serial pattern detector controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_detect_pkg;

  localparam int MAXW_DEF = 4;
  localparam int CNTW_DEF = 8;
  localparam int LENW_DEF = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Host/bit-source bundle for seq_detect_ctrl: frame control, serial bits, status.
// Latency: n/a (wiring only).
// Backpressure: none; x_valid qualifies bits, the detector always accepts in RUN.
interface seq_detect_ctrl_if
  import seq_detect_pkg::*;
#(
  parameter int MAXW = MAXW_DEF,
  parameter int CNTW = CNTW_DEF,
  parameter int LENW = LENW_DEF
);
  logic            start;
  logic            abort;
  logic [MAXW-1:0] pattern;
  logic [LENW-1:0] pat_len;
  logic [CNTW-1:0] frame_len;
  logic            x;
  logic            x_valid;
  logic            busy;
  logic            hit;
  logic            done;
  logic            aborted;
  logic [CNTW-1:0] match_count;

  // Host / stimulus side.
  modport master (
    output start, abort, pattern, pat_len, frame_len, x, x_valid,
    input  busy, hit, done, aborted, match_count
  );

  // Detector side.
  modport slave (
    input  start, abort, pattern, pat_len, frame_len, x, x_valid,
    output busy, hit, done, aborted, match_count
  );
endinterface

// File: rtl/seq_detect_ctrl_pattern_match.sv
// History shift register with a length-masked compare against the pattern.
// Latency: match is combinational on the incoming bit; history updates next edge.
// Backpressure: none; shifts only when shift_en is high.
module pattern_match
  import seq_detect_pkg::*;
#(
  parameter int MAXW = MAXW_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            shift_en,
  input  logic            x,
  input  logic [MAXW-1:0] pattern,
  input  logic [LENW-1:0] eff_len,
  output logic            match,
  output logic            full
);

  logic [MAXW-1:0] history;
  logic [LENW-1:0] fill;
  logic [MAXW-1:0] cand;
  logic [MAXW-1:0] mask;

  // Newest bit enters at the LSB; fill saturates once the register is full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      history <= '0;
      fill    <= '0;
    end else if (clr) begin
      history <= '0;
      fill    <= '0;
    end else if (shift_en) begin
      history <= {history[MAXW-2:0], x};
      if (fill != LENW'(MAXW)) fill <= fill + LENW'(1);
    end
  end

  // Compare only the low eff_len bits of the window that includes the incoming bit.
  always_comb begin
    cand = {history[MAXW-2:0], x};
    mask = '0;
    for (int i = 0; i < MAXW; i++) mask[i] = (i < int'(eff_len));
    match = (((cand ^ pattern) & mask) == '0);
    full  = (fill >= eff_len);
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Frame sequencer around pattern_match: latch config, clear, count bits and hits.
// Latency: start->first bit 2 cycles; last bit->done 1 cycle; hit is same-cycle.
// Backpressure: none; bits are taken whenever x_valid is high in RUN.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int MAXW = MAXW_DEF,
  parameter int CNTW = CNTW_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  seq_detect_ctrl_if.slave  bus
);

  state_t          state;
  logic [MAXW-1:0] pat_q;
  logic [LENW-1:0] len_q;
  logic [CNTW-1:0] frame_q;
  logic [CNTW-1:0] bits_seen;
  logic [CNTW-1:0] count_q;
  logic            busy_q;
  logic            done_q;
  logic            aborted_q;

  logic [LENW-1:0] eff_len;
  logic            accept;
  logic            match;
  logic            full;
  logic            window_ok;
  logic            hit;
  logic            last_bit;

  // Zero length behaves as a one-bit pattern; anything wider than the register is clamped.
  always_comb begin
    if (len_q == '0)                eff_len = LENW'(1);
    else if (len_q > LENW'(MAXW))   eff_len = LENW'(MAXW);
    else                            eff_len = len_q;
  end

  // A bit is accepted only in RUN, when valid and not pre-empted by abort.
  always_comb begin
    accept    = (state == S_RUN) && bus.x_valid && !bus.abort;
    window_ok = full || ((bits_seen + CNTW'(1)) == CNTW'(eff_len));
    hit       = accept && match && window_ok;
    last_bit  = ((bits_seen + CNTW'(1)) == frame_q);
  end

  pattern_match #(
    .MAXW (MAXW),
    .LENW (LENW)
  ) u_match (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == S_ARM),
    .shift_en (accept),
    .x        (bus.x),
    .pattern  (pat_q),
    .eff_len  (eff_len),
    .match    (match),
    .full     (full)
  );

  // Frame FSM with registered busy/done/aborted and the bit and match counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      frame_q   <= '0;
      bits_seen <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            pat_q     <= bus.pattern;
            len_q     <= bus.pat_len;
            frame_q   <= bus.frame_len;
            aborted_q <= 1'b0;
            count_q   <= '0;
            busy_q    <= 1'b1;
            state     <= S_ARM;
          end
        end
        S_ARM: begin
          bits_seen <= '0;
          if (frame_q == '0) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end else if (bus.abort) begin
            aborted_q <= 1'b1;
            done_q    <= 1'b1;
            state     <= S_DONE;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            aborted_q <= 1'b1;
            done_q    <= 1'b1;
            state     <= S_DONE;
          end else if (bus.x_valid) begin
            bits_seen <= bits_seen + CNTW'(1);
            if (hit && (count_q != '1)) count_q <= count_q + CNTW'(1);
            if (last_bit) begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;
  assign bus.match_count = count_q;
  assign bus.hit         = hit;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed-vector bench for seq_detect_ctrl with hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_detect_ctrl;
  import seq_detect_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  seq_detect_ctrl_if bus ();

  seq_detect_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start handshake, then scramble config to show it was latched; returns in RUN.
  task automatic start_frame(input logic [3:0] pat, input logic [2:0] len, input logic [7:0] flen);
    bus.start     = 1'b1;
    bus.pattern   = pat;
    bus.pat_len   = len;
    bus.frame_len = flen;
    step();
    bus.start     = 1'b0;
    bus.pattern   = ~pat;
    bus.pat_len   = 3'd0;
    bus.frame_len = 8'd1;
    step();
  endtask

  task automatic send_bit(input logic b, input logic exp_hit, input string tag);
    bus.x       = b;
    bus.x_valid = 1'b1;
    @(negedge clk);
    check_eq(tag, {31'd0, bus.hit}, {31'd0, exp_hit});
    step();
    bus.x_valid = 1'b0;
  endtask

  task automatic gap(input string tag);
    bus.x       = 1'b1;
    bus.x_valid = 1'b0;
    @(negedge clk);
    check_eq(tag, {31'd0, bus.hit}, 32'd0);
    step();
  endtask

  // Called right after the edge that should have entered DONE.
  task automatic expect_done(input string tag, input int cnt, input logic ab);
    check_eq({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    check_eq({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    check_eq({tag, "_count"}, {24'd0, bus.match_count}, cnt);
    check_eq({tag, "_aborted"}, {31'd0, bus.aborted}, {31'd0, ab});
    step();
    check_eq({tag, "_done_off"}, {31'd0, bus.done}, 32'd0);
    check_eq({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    bus.start = 0; bus.abort = 0; bus.pattern = '0; bus.pat_len = '0;
    bus.frame_len = '0; bus.x = 0; bus.x_valid = 0;

    // Reset state
    #2;
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_done", {31'd0, bus.done}, 32'd0);
    check_eq("rst_hit", {31'd0, bus.hit}, 32'd0);
    check_eq("rst_aborted", {31'd0, bus.aborted}, 32'd0);
    check_eq("rst_count", {24'd0, bus.match_count}, 32'd0);
    step();
    rst = 1'b1;
    step();

    // 101 over 1,0,1,0,1: hits on bits 3 and 5
    start_frame(4'b0101, 3'd3, 8'd5);
    check_eq("t1_busy_run", {31'd0, bus.busy}, 32'd1);
    send_bit(1, 0, "t1_b1");
    send_bit(0, 0, "t1_b2");
    send_bit(1, 1, "t1_b3");
    send_bit(0, 0, "t1_b4");
    send_bit(1, 1, "t1_b5");
    expect_done("t1", 2, 0);

    // 1111 over six ones: hits on 4,5,6
    start_frame(4'b1111, 3'd4, 8'd6);
    for (int i = 0; i < 6; i++) send_bit(1, i >= 3, $sformatf("t2_b%0d", i + 1));
    expect_done("t2", 3, 0);

    // Same with gaps between bits
    start_frame(4'b1111, 3'd4, 8'd6);
    for (int i = 0; i < 6; i++) begin
      gap($sformatf("t2g_gap%0d", i + 1));
      send_bit(1, i >= 3, $sformatf("t2g_b%0d", i + 1));
    end
    expect_done("t2g", 3, 0);

    // Carry-over: previous frame ends 1,0; new frame 1,0,0 must not hit
    start_frame(4'b0101, 3'd3, 8'd2);
    send_bit(1, 0, "t3a_b1");
    send_bit(0, 0, "t3a_b2");
    expect_done("t3a", 0, 0);
    start_frame(4'b0101, 3'd3, 8'd3);
    send_bit(1, 0, "t3_b1");
    send_bit(0, 0, "t3_b2");
    send_bit(0, 0, "t3_b3");
    expect_done("t3", 0, 0);

    // frame_len==0: ARM -> DONE, done two edges after start
    bus.start = 1'b1; bus.pattern = 4'b0001; bus.pat_len = 3'd1; bus.frame_len = 8'd0;
    step();
    bus.start = 1'b0;
    check_eq("t4_arm_done", {31'd0, bus.done}, 32'd0);
    step();
    expect_done("t4", 0, 0);

    // pat_len==0 treated as 1, pattern bit0=1, bits 1,1,0
    start_frame(4'b0001, 3'd0, 8'd3);
    send_bit(1, 1, "t4b_b1");
    send_bit(1, 1, "t4b_b2");
    send_bit(0, 0, "t4b_b3");
    expect_done("t4b", 2, 0);

    // pat_len>MAXW clamps to 4: pattern 1001
    start_frame(4'b1001, 3'd7, 8'd4);
    send_bit(1, 0, "t4c_b1");
    send_bit(0, 0, "t4c_b2");
    send_bit(0, 0, "t4c_b3");
    send_bit(1, 1, "t4c_b4");
    expect_done("t4c", 1, 0);

    // Abort on bit 3 of 8 together with x_valid: bit dropped, no hit
    start_frame(4'b0011, 3'd2, 8'd8);
    send_bit(1, 0, "t5_b1");
    send_bit(1, 1, "t5_b2");
    bus.abort = 1'b1;
    send_bit(1, 0, "t5_abort_bit");
    bus.abort = 1'b0;
    expect_done("t5", 1, 1);
    check_eq("t5_aborted_held", {31'd0, bus.aborted}, 32'd1);
    bus.start = 1'b1; bus.pattern = 4'b0011; bus.pat_len = 3'd2; bus.frame_len = 8'd1;
    step();
    bus.start = 1'b0;
    check_eq("t5_aborted_clr", {31'd0, bus.aborted}, 32'd0);
    step();
    send_bit(1, 0, "t5n_b1");
    expect_done("t5n", 0, 0);

    // Reset mid-RUN
    start_frame(4'b0011, 3'd2, 8'd8);
    send_bit(1, 0, "t6_b1");
    send_bit(1, 1, "t6_b2");
    check_eq("t6_pre_count", {24'd0, bus.match_count}, 32'd1);
    bus.x = 1'b1; bus.x_valid = 1'b1;
    #1;
    check_eq("t6_pre_hit", {31'd0, bus.hit}, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("t6_rst_hit", {31'd0, bus.hit}, 32'd0);
    check_eq("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("t6_rst_count", {24'd0, bus.match_count}, 32'd0);
    bus.x_valid = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("t6_no_done%0d", i), {31'd0, bus.done}, 32'd0);
    end

    // start during RUN ignored, config unchanged
    start_frame(4'b0101, 3'd3, 8'd4);
    bus.start = 1'b1; bus.pattern = 4'b0000; bus.pat_len = 3'd1; bus.frame_len = 8'd1;
    send_bit(1, 0, "t7_b1");
    bus.start = 1'b0;
    check_eq("t7_still_busy", {31'd0, bus.busy}, 32'd1);
    check_eq("t7_no_done", {31'd0, bus.done}, 32'd0);
    send_bit(0, 0, "t7_b2");
    send_bit(1, 1, "t7_b3");
    send_bit(1, 0, "t7_b4");
    expect_done("t7", 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
